// File: rtl/lab_defs_pkg.sv
// Shared definitions for the lab CPU memory/I-O bridge: command encoding,
// I/O addresses and the bridge state type.
package lab_defs_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RAM_WAIT = 2'b01,
    DONE     = 2'b10
  } bridge_state_t;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU-side memory port of the bridge. The CPU holds mem_cmd/mem_addr/write_data
// stable until it sees the one-cycle mem_ready pulse; read_data is valid with it.
interface mem_io_bridge_if;
  import lab_defs_pkg::*;

  mem_cmd_t    mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        bus_err;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ready, bus_err
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ready, bus_err
  );
endinterface

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchroniser, plus a stability counter when
// MEM_IO_BRIDGE_DEBOUNCE_EN is defined (otherwise the synchronised bit passes through).
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_filt
);

  logic sync_q1;
  logic sw_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sync_q1 <= sw_raw;
      sw_sync <= sync_q1;
    end
  end

`ifdef MEM_IO_BRIDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Any return to the filtered value restarts the stability window.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      sw_filt <= 1'b0;
    end else if (sw_sync == sw_filt) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      sw_filt <= sw_sync;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign sw_filt = sw_sync;
`endif

endmodule

// File: rtl/mem_io_bridge.sv
// Decodes CPU accesses to RAM (0x000-0x0FF), LED register (0x100) and switches
// (0x140); optional switch debounce via MEM_IO_BRIDGE_DEBOUNCE_EN.
module mem_io_bridge
  import lab_defs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_io_bridge_if.slave   bus,
  output logic [7:0]       ram_addr,
  output logic [15:0]      ram_wdata,
  output logic             ram_write,
  input  logic [15:0]      ram_rdata,
  input  logic [7:0]       sw_in,
  output logic [7:0]       ledr_out,
  output bridge_state_t    state_dbg
);

  bridge_state_t state, state_nxt;
  logic [7:0]    sw_filt;
  logic          is_ram, is_led, is_sw;

  for (genvar i = 0; i < 8; i++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
      .clk     (clk),
      .reset   (reset),
      .sw_raw  (sw_in[i]),
      .sw_filt (sw_filt[i])
    );
  end

  assign is_ram = ~bus.mem_addr[8];
  assign is_led = (bus.mem_addr == LED_ADDR);
  assign is_sw  = (bus.mem_addr == SW_ADDR);

  assign ram_addr      = bus.mem_addr[7:0];
  assign ram_wdata     = bus.write_data;
  // Gated by reset so a write never escapes in a reset cycle.
  assign ram_write     = (state == IDLE) && (bus.mem_cmd == MWRITE) && is_ram && !reset;
  assign bus.mem_ready = (state == DONE);
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.mem_cmd == MREAD && is_ram) state_nxt = RAM_WAIT;
        else if (bus.mem_cmd != MNONE)      state_nxt = DONE;
      end
      RAM_WAIT: state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // I/O and illegal accesses complete on the IDLE edge; RAM reads land in RAM_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.read_data <= 16'h0000;
      bus.bus_err   <= 1'b0;
      ledr_out      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_cmd == MWRITE) begin
            if (is_led)       ledr_out    <= bus.write_data[7:0];
            else if (!is_ram) bus.bus_err <= 1'b1;
          end else if (bus.mem_cmd == MREAD) begin
            if (is_sw) begin
              bus.read_data <= {8'h00, sw_filt};
            end else if (!is_ram) begin
              bus.read_data <= 16'h0000;
              bus.bus_err   <= 1'b1;
            end
          end
        end
        RAM_WAIT: bus.read_data <= ram_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a behavioural synchronous RAM.
module tb_mem_io_bridge;
  import lab_defs_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    ram_addr;
  logic [15:0]   ram_wdata;
  logic          ram_write;
  logic [15:0]   ram_rdata;
  logic [7:0]    sw_in;
  logic [7:0]    ledr_out;
  bridge_state_t state_dbg;
  logic [15:0]   ram_mem [256];

  int errors = 0;
  int checks = 0;

  mem_io_bridge_if bus_if ();

  mem_io_bridge #(.DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_write (ram_write),
    .ram_rdata (ram_rdata),
    .sw_in     (sw_in),
    .ledr_out  (ledr_out),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // RAM: read data valid one cycle after the address.
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input mem_cmd_t cmd, input logic [8:0] addr, input logic [15:0] wd);
    bus_if.mem_cmd    = cmd;
    bus_if.mem_addr   = addr;
    bus_if.write_data = wd;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    sw_in = 8'h00;
    drive(MNONE, 9'h000, 16'h0000);
    tick(3);
    reset = 1'b0;
    tick();
    chk("rst_state", {14'b0, state_dbg}, {14'b0, IDLE});
    chk("rst_read_data", bus_if.read_data, 16'h0000);
    chk("rst_ready", {15'b0, bus_if.mem_ready}, 16'h0000);
    chk("rst_bus_err", {15'b0, bus_if.bus_err}, 16'h0000);
    chk("rst_ledr", {8'h00, ledr_out}, 16'h0000);
    chk("rst_ram_write", {15'b0, ram_write}, 16'h0000);

    // RAM write 0x005 <= 0x1234
    drive(MWRITE, 9'h005, 16'h1234);
    chk("wr_ram_write_hi", {15'b0, ram_write}, 16'h0001);
    chk("wr_ram_addr", {8'h00, ram_addr}, 16'h0005);
    tick();
    chk("wr_ready", {15'b0, bus_if.mem_ready}, 16'h0001);
    chk("wr_ram_write_lo", {15'b0, ram_write}, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
    chk("wr_ready_drop", {15'b0, bus_if.mem_ready}, 16'h0000);

    // RAM write 0x0FF <= 0xBEEF (top of RAM)
    drive(MWRITE, 9'h0FF, 16'hBEEF);
    tick();
    drive(MNONE, 9'h000, 16'h0000);
    tick();

    // RAM read 0x005: two-cycle latency
    drive(MREAD, 9'h005, 16'h0000);
    chk("rd_no_ram_write", {15'b0, ram_write}, 16'h0000);
    tick();
    chk("rd_state_wait", {14'b0, state_dbg}, {14'b0, RAM_WAIT});
    chk("rd_ready_early", {15'b0, bus_if.mem_ready}, 16'h0000);
    tick();
    chk("rd_ready", {15'b0, bus_if.mem_ready}, 16'h0001);
    chk("rd_data_005", bus_if.read_data, 16'h1234);
    drive(MNONE, 9'h000, 16'h0000);
    tick();

    drive(MREAD, 9'h0FF, 16'h0000);
    tick(2);
    chk("rd_data_0ff", bus_if.read_data, 16'hBEEF);
    drive(MNONE, 9'h000, 16'h0000);
    tick();

    // LED write
    drive(MWRITE, LED_ADDR, 16'h55A5);
    chk("led_no_ram_write", {15'b0, ram_write}, 16'h0000);
    tick();
    chk("led_value", {8'h00, ledr_out}, 16'h00A5);
    chk("led_ready", {15'b0, bus_if.mem_ready}, 16'h0001);
    chk("led_rd_hold", bus_if.read_data, 16'hBEEF);
    chk("led_no_err", {15'b0, bus_if.bus_err}, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    tick();

    // Switch read after long hold
    sw_in = 8'd15;
    tick(40);
    drive(MREAD, SW_ADDR, 16'h0000);
    tick();
    chk("sw_ready", {15'b0, bus_if.mem_ready}, 16'h0001);
    chk("sw_data", bus_if.read_data, 16'h000F);
    chk("sw_no_err", {15'b0, bus_if.bus_err}, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    tick();

`ifndef MEM_IO_BRIDGE_DEBOUNCE_EN
    // Synchroniser latency: one edge is too soon, two edges suffice.
    sw_in = 8'hC3;
    tick();
    drive(MREAD, SW_ADDR, 16'h0000);
    tick();
    chk("sw_lat_1", bus_if.read_data, 16'h000F);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
    sw_in = 8'h3C;
    tick(2);
    drive(MREAD, SW_ADDR, 16'h0000);
    tick();
    chk("sw_lat_2", bus_if.read_data, 16'h003C);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
`else
    // Short glitch is filtered; a long hold gets through.
    sw_in = 8'h00;
    tick(40);
    sw_in = 8'h01;
    tick(3);
    sw_in = 8'h00;
    tick(30);
    drive(MREAD, SW_ADDR, 16'h0000);
    tick();
    chk("deb_glitch", bus_if.read_data, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
    sw_in = 8'h01;
    tick(22);
    drive(MREAD, SW_ADDR, 16'h0000);
    tick();
    chk("deb_hold", bus_if.read_data, 16'h0001);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
`endif

    // Illegal: write to switch address, then read of unmapped address
    drive(MWRITE, SW_ADDR, 16'h00FF);
    chk("ill_no_ram_write", {15'b0, ram_write}, 16'h0000);
    tick();
    chk("ill_wr_ready", {15'b0, bus_if.mem_ready}, 16'h0001);
    chk("ill_wr_err", {15'b0, bus_if.bus_err}, 16'h0001);
    chk("ill_ledr_same", {8'h00, ledr_out}, 16'h00A5);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
    chk("ill_err_sticky", {15'b0, bus_if.bus_err}, 16'h0001);
    drive(MREAD, 9'h1FF, 16'h0000);
    tick();
    chk("ill_rd_ready", {15'b0, bus_if.mem_ready}, 16'h0001);
    chk("ill_rd_data", bus_if.read_data, 16'h0000);
    chk("ill_rd_err", {15'b0, bus_if.bus_err}, 16'h0001);
    drive(MNONE, 9'h000, 16'h0000);
    tick();

    // Reading the write-only LED register is illegal too
    drive(MREAD, 9'h005, 16'h0000);
    tick(2);
    drive(MNONE, 9'h000, 16'h0000);
    tick();
    drive(MREAD, LED_ADDR, 16'h0000);
    tick();
    chk("led_rd_data", bus_if.read_data, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    tick();

    // Reset while in RAM_WAIT
    drive(MREAD, 9'h005, 16'h0000);
    tick();
    chk("mid_state_wait", {14'b0, state_dbg}, {14'b0, RAM_WAIT});
    reset = 1'b1;
    tick();
    chk("mid_state_idle", {14'b0, state_dbg}, {14'b0, IDLE});
    chk("mid_no_ready", {15'b0, bus_if.mem_ready}, 16'h0000);
    chk("mid_read_data", bus_if.read_data, 16'h0000);
    chk("mid_bus_err", {15'b0, bus_if.bus_err}, 16'h0000);
    chk("mid_ledr", {8'h00, ledr_out}, 16'h0000);
    drive(MWRITE, 9'h005, 16'hDEAD);
    chk("rst_blocks_write", {15'b0, ram_write}, 16'h0000);
    tick();
    chk("rst_hold_no_ready", {15'b0, bus_if.mem_ready}, 16'h0000);
    drive(MNONE, 9'h000, 16'h0000);
    reset = 1'b0;
    tick();
    chk("post_rst_no_ready", {15'b0, bus_if.mem_ready}, 16'h0000);

    // RAM still holds the pre-reset value (the write during reset was blocked)
    drive(MREAD, 9'h005, 16'h0000);
    tick(2);
    chk("post_rst_ram", bus_if.read_data, 16'h1234);
    drive(MNONE, 9'h000, 16'h0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
